// File: rtl/fib_pkg.sv
// Shared widths and FSM encoding for the Fibonacci job sequencer.
package fib_pkg;
  localparam int N_W_DEF   = 5;
  localparam int RES_W_DEF = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_e;
endpackage

// File: rtl/fib_req_fifo.sv
// Request FIFO with synchronous reset; pointers wrap, count is one bit wider.
module fib_req_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/fib_job_sequencer.sv
// Queues N requests, launches the Fibonacci core once per request, and returns
// each result (or a watchdog timeout) in request order over valid/ready.
module fib_job_sequencer
  import fib_pkg::*;
#(
  parameter int N_W     = N_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_W-1:0]   out_n,
  output logic [RES_W-1:0] out_result,
  output logic             out_timeout,
  output logic             core_rst,
  output logic [N_W-1:0]   core_n,
  input  logic             core_done,
  input  logic [RES_W-1:0] core_result,
  output logic             busy
);
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

  // Both ports transfer on the rising edge where valid & ready are high; a
  // producer holds valid and its data stable until that edge.
  state_e             state_q, state_d;
  logic [N_W-1:0]     core_n_q, core_n_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               out_valid_q, out_valid_d;
  logic [N_W-1:0]     out_n_q, out_n_d;
  logic [RES_W-1:0]   out_result_q, out_result_d;
  logic               out_timeout_q, out_timeout_d;

  logic               fifo_pop;
  logic [N_W-1:0]     fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  fib_req_fifo #(.W(N_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid & in_ready),
    .wdata (in_n),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    core_n_d      = core_n_q;
    wdog_d        = wdog_q;
    out_valid_d   = out_valid_q;
    out_n_d       = out_n_q;
    out_result_d  = out_result_q;
    out_timeout_d = out_timeout_q;
    fifo_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          core_n_d = fifo_rdata;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: state_d = SETTLE;
      SETTLE: begin
        // done may still be high from the previous job; it is not looked at here.
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wdog_q != WD_MAX) wdog_d = wdog_q + 1'b1;
        if (core_done) begin
          out_result_d  = core_result;
          out_n_d       = core_n_q;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = HOLD;
        end else if (wdog_q == WD_LAST) begin
          out_result_d  = '0;
          out_n_d       = core_n_q;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      core_n_q      <= '0;
      wdog_q        <= '0;
      out_valid_q   <= 1'b0;
      out_n_q       <= '0;
      out_result_q  <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      core_n_q      <= core_n_d;
      wdog_q        <= wdog_d;
      out_valid_q   <= out_valid_d;
      out_n_q       <= out_n_d;
      out_result_q  <= out_result_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign in_ready    = ~fifo_full;
  assign core_rst    = rst | (state_q == LAUNCH);
  assign core_n      = core_n_q;
  assign out_valid   = out_valid_q;
  assign out_n       = out_n_q;
  assign out_result  = out_result_q;
  assign out_timeout = out_timeout_q;
  assign busy        = (state_q != IDLE) | (fifo_count != '0);
endmodule

// File: tb/tb_fib_job_sequencer.sv
// Directed bench for fib_job_sequencer with a stub core and a result scoreboard.
module tb_fib_job_sequencer;
  localparam int N_W     = 5;
  localparam int RES_W   = 64;
  localparam int TIMEOUT = 50;
  localparam int EXP_W   = 1 + N_W + RES_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_W-1:0]   in_n = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N_W-1:0]   out_n;
  logic [RES_W-1:0] out_result;
  logic             out_timeout;
  logic             core_rst;
  logic [N_W-1:0]   core_n;
  logic             core_done;
  logic [RES_W-1:0] core_result;
  logic             busy;

  fib_job_sequencer #(.N_W(N_W), .RES_W(RES_W), .DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_n        (in_n),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_n       (out_n),
    .out_result  (out_result),
    .out_timeout (out_timeout),
    .core_rst    (core_rst),
    .core_n      (core_n),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stub core ----------------
  // done rises N+5 cycles after rst falls with result N*3 and then stays high.
  logic       stale_mode = 1'b0;
  logic       never_done = 1'b0;
  logic [5:0] stub_cnt;
  logic       stub_done;
  logic [RES_W-1:0] stub_res;
  always @(posedge clk) begin
    if (core_rst) begin
      stub_cnt <= '0;
      if (!stale_mode) begin
        stub_done <= 1'b0;
        stub_res  <= '0;
      end
    end else begin
      if (stub_cnt != 6'd63) stub_cnt <= stub_cnt + 6'd1;
      if (!never_done && (int'(stub_cnt) + 1 >= int'(core_n) + 5)) begin
        stub_done <= 1'b1;
        stub_res  <= RES_W'(core_n) * 64'd3;
      end else begin
        stub_done <= 1'b0;
        stub_res  <= '0;
      end
    end
  end
  assign core_done   = stub_done;
  assign core_result = stub_res;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int launch_cyc = 0;
  int hs_cyc = 0;
  int acc_cyc = 0;

  task automatic chk(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic ov_prev = 1'b0, hs_prev = 1'b0, rst_prev = 1'b1, crst_prev = 1'b1;
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    int lat_req;
    if (!rst) begin
      if (core_rst) begin
        chk("core_rst_width", EXP_W'(crst_prev && !rst_prev), EXP_W'(0));
        launch_cyc = cyc;
      end
      if (ov_prev && !hs_prev && !rst_prev)
        chk("out_valid_hold", EXP_W'(out_valid), EXP_W'(1));
      if (out_valid) begin
        chk("no_launch_in_hold", EXP_W'(core_rst), EXP_W'(0));
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {out_timeout, out_n, out_result}, '1);
        end else begin
          e = exp_q[0];
          chk("result", {out_timeout, out_n, out_result}, e);
          if (!ov_prev) begin
            lat_req = e[EXP_W-1] ? TIMEOUT + 2 : int'(e[EXP_W-2 -: N_W]) + 7;
            chk("launch_to_valid", EXP_W'(cyc - launch_cyc), EXP_W'(lat_req));
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_cyc = cyc;
          end
        end
      end
    end
    ov_prev   = out_valid;
    hs_prev   = out_valid && out_ready;
    rst_prev  = rst;
    crst_prev = core_rst;
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N_W-1:0] n, input logic to);
    int w = 0;
    logic [RES_W-1:0] r;
    in_valid = 1'b1;
    in_n     = n;
    @(negedge clk);
    while (!in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("push_accept_bound", EXP_W'(0), EXP_W'(1));
      in_valid = 1'b0;
      tick(1);
    end else begin
      r = to ? '0 : RES_W'(n) * 64'd3;
      exp_q.push_back({to, n, r});
      acc_cyc = cyc;
      tick(1);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_launch(output int lc);
    int w = 0;
    @(negedge clk);
    while (!(core_rst && !rst) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("launch_bound", EXP_W'(core_rst && !rst), EXP_W'(1));
    lc = cyc;
  endtask

  task automatic wait_valid();
    int w = 0;
    @(negedge clk);
    while (!out_valid && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("valid_bound", EXP_W'(out_valid), EXP_W'(1));
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((busy || out_valid || exp_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("idle_bound", EXP_W'(busy || out_valid || exp_q.size() != 0), EXP_W'(0));
    tick(1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lc, a0, h;
    // reset state
    tick(1);
    @(negedge clk);
    chk("core_rst_in_reset", EXP_W'(core_rst), EXP_W'(1));
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", EXP_W'(out_valid), EXP_W'(0));
    chk("rst_in_ready", EXP_W'(in_ready), EXP_W'(1));
    chk("rst_busy", EXP_W'(busy), EXP_W'(0));
    chk("rst_outputs", {out_timeout, out_n, out_result}, '0);
    chk("rst_core", EXP_W'({core_rst, core_n}), EXP_W'(0));
    tick(1);

    // 1: single job, launch two cycles after acceptance
    push(5'd10, 1'b0);
    a0 = acc_cyc;
    wait_launch(lc);
    chk("accept_to_launch", EXP_W'(lc - a0), EXP_W'(2));
    chk("core_n_launch", EXP_W'(core_n), EXP_W'(10));
    tick(1);
    wait_idle();

    // 2: burst fills the FIFO behind the running job
    push(5'd5, 1'b0);
    a0 = acc_cyc;
    push(5'd0, 1'b0);
    push(5'd31, 1'b0);
    push(5'd1, 1'b0);
    push(5'd2, 1'b0);
    chk("burst_back_to_back", EXP_W'(acc_cyc - a0), EXP_W'(4));
    in_valid = 1'b1;
    in_n     = 5'd3;
    @(negedge clk);
    chk("full_in_ready", EXP_W'(in_ready), EXP_W'(0));
    tick(1);
    push(5'd3, 1'b0);
    wait_idle();

    // 3: backpressure in HOLD, next launch right after release
    out_ready = 1'b0;
    push(5'd6, 1'b0);
    push(5'd8, 1'b0);
    wait_valid();
    tick(20);
    out_ready = 1'b1;
    @(negedge clk);
    h = cyc;
    wait_launch(lc);
    chk("release_to_launch", EXP_W'(lc - h), EXP_W'(2));
    tick(1);
    wait_idle();

    // 4: watchdog timeout, then a normal job
    never_done = 1'b1;
    push(5'd9, 1'b1);
    wait_valid();
    never_done = 1'b0;
    tick(1);
    push(5'd12, 1'b0);
    wait_idle();

    // 5: stale done held through LAUNCH/SETTLE
    stale_mode = 1'b1;
    push(5'd4, 1'b0);
    push(5'd7, 1'b0);
    wait_idle();
    stale_mode = 1'b0;

    // 6: reset mid-WAIT with two jobs queued
    push(5'd20, 1'b0);
    push(5'd21, 1'b0);
    push(5'd22, 1'b0);
    wait_launch(lc);
    tick(8);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", EXP_W'(in_ready), EXP_W'(1));
    chk("midrst_busy", EXP_W'(busy), EXP_W'(0));
    chk("midrst_out_valid", EXP_W'(out_valid), EXP_W'(0));
    tick(80);
    push(5'd3, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
